// File: rtl/tdl_phase_ctrl.sv
// Break-before-make tap-select controller for an N-tap tristate delay line.
// Optional lock detector is built when TDL_LOCK_DET_EN is defined.
module tdl_phase_ctrl #(
  parameter int N_TAPS   = 8,
  parameter int CODE_W   = 3,
  parameter int FILT_LEN = 4,
  parameter int LOCK_CNT = 8,
  parameter int INIT_TAP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              vote_vld,
  input  logic              phase_up,
  input  logic              phase_dn,
  input  logic              man_load,
  input  logic [CODE_W-1:0] man_code,
  output logic [N_TAPS-1:0] lambda,
  output logic [N_TAPS-1:0] lambda_bar,
  output logic [CODE_W-1:0] tap_code,
  output logic              busy,
  output logic              sat,
  output logic              locked
);

  localparam int ACC_W = $clog2(FILT_LEN + 1) + 1;
  typedef logic signed [ACC_W-1:0] acc_t;
  localparam acc_t ACC_MAX = acc_t'(FILT_LEN);
  localparam acc_t ACC_MIN = acc_t'(-FILT_LEN);
  localparam logic [CODE_W-1:0] MAX_TAP   = CODE_W'(N_TAPS - 1);
  localparam logic [CODE_W-1:0] INIT_CODE = CODE_W'(INIT_TAP);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAKE} state_t;

  function automatic logic [N_TAPS-1:0] sel_enc(input logic [CODE_W-1:0] t);
    logic [N_TAPS-1:0] v;
    v = '0;
    for (int k = 0; k < N_TAPS; k++) v[k] = (k == int'(t));
    return v;
  endfunction

  // Top bit can never be set because t never exceeds N_TAPS-1.
  function automatic logic [N_TAPS-1:0] pass_enc(input logic [CODE_W-1:0] t);
    logic [N_TAPS-1:0] v;
    v = '0;
    for (int k = 0; k < N_TAPS; k++) v[k] = (k < int'(t));
    return v;
  endfunction

  state_t            state, state_n;
  acc_t              acc, acc_n, acc_v;
  logic [CODE_W-1:0] tgt, tgt_n, man_clamped;
  logic [31:0]       man_ext;
  logic              sat_n;

  assign man_ext     = 32'(man_code);
  assign man_clamped = (man_ext >= 32'(N_TAPS)) ? MAX_TAP : man_code;

  // vote_vld qualifies phase_up/phase_dn for one cycle; there is no back-pressure,
  // so a vote arriving while busy is simply dropped.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    tgt_n   = tgt;
    sat_n   = 1'b0;
    acc_v   = acc;
    if (!en) acc_n = '0;
    case (state)
      S_IDLE: begin
        if (man_load) begin
          acc_n = '0;
          if (man_clamped != tap_code) begin
            state_n = S_BREAK;
            tgt_n   = man_clamped;
          end
        end else if (en && vote_vld && (phase_up ^ phase_dn)) begin
          acc_v = phase_up ? acc + acc_t'(1) : acc - acc_t'(1);
          if (acc_v == ACC_MAX) begin
            acc_n = '0;
            if (tap_code == MAX_TAP) begin
              sat_n = 1'b1;
            end else begin
              state_n = S_BREAK;
              tgt_n   = tap_code + CODE_W'(1);
            end
          end else if (acc_v == ACC_MIN) begin
            acc_n = '0;
            if (tap_code == '0) begin
              sat_n = 1'b1;
            end else begin
              state_n = S_BREAK;
              tgt_n   = tap_code - CODE_W'(1);
            end
          end else begin
            acc_n = acc_v;
          end
        end
      end
      S_BREAK: state_n = S_MAKE;
      S_MAKE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      tgt        <= INIT_CODE;
      sat        <= 1'b0;
      busy       <= 1'b0;
      tap_code   <= INIT_CODE;
      lambda     <= sel_enc(INIT_CODE);
      lambda_bar <= pass_enc(INIT_CODE);
    end else begin
      state <= state_n;
      acc   <= acc_n;
      tgt   <= tgt_n;
      sat   <= sat_n;
      busy  <= (state_n != S_IDLE);
      if (state == S_BREAK) begin
        lambda     <= '0;
        lambda_bar <= pass_enc(tap_code) & pass_enc(tgt);
      end
      if (state == S_MAKE) begin
        lambda     <= sel_enc(tgt);
        lambda_bar <= pass_enc(tgt);
        tap_code   <= tgt;
      end
    end
  end

`ifdef TDL_LOCK_DET_EN
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  logic [CNT_W-1:0] rev_cnt;
  logic             prev_vld, prev_up, load_seq, step_up, lock_clr, man_acc;

  assign man_acc  = (state == S_IDLE) && man_load;
  assign lock_clr = sat_n || !en || man_acc;
  // tap_code still holds the old tap while in MAKE.
  assign step_up  = (tgt > tap_code);

  // Manual jumps are not steps: they restart lock tracking from scratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_cnt  <= '0;
      prev_vld <= 1'b0;
      prev_up  <= 1'b0;
      load_seq <= 1'b0;
      locked   <= 1'b0;
    end else if (lock_clr) begin
      rev_cnt  <= '0;
      prev_vld <= 1'b0;
      locked   <= 1'b0;
      load_seq <= man_acc && (state_n == S_BREAK);
    end else if (state == S_MAKE) begin
      load_seq <= 1'b0;
      if (!load_seq) begin
        prev_vld <= 1'b1;
        prev_up  <= step_up;
        if (prev_vld && (prev_up != step_up)) begin
          if (rev_cnt != CNT_W'(LOCK_CNT)) rev_cnt <= rev_cnt + CNT_W'(1);
          if (rev_cnt >= CNT_W'(LOCK_CNT - 1)) locked <= 1'b1;
        end else if (prev_vld) begin
          rev_cnt <= '0;
          locked  <= 1'b0;
        end
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_tdl_phase_ctrl.sv
// Directed bench for tdl_phase_ctrl: stepping, limits, manual load, lock and reset.
// CODE_W is widened to 4 so an out-of-range manual code (9) can be presented.
module tb_tdl_phase_ctrl;
  localparam int N  = 8;
  localparam int CW = 4;
`ifdef TDL_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          vote_vld = 1'b0;
  logic          phase_up = 1'b0;
  logic          phase_dn = 1'b0;
  logic          man_load = 1'b0;
  logic [CW-1:0] man_code = '0;
  logic [N-1:0]  lambda, lambda_bar;
  logic [CW-1:0] tap_code;
  logic          busy, sat, locked;

  int n_cmp = 0;
  int n_err = 0;

  tdl_phase_ctrl #(
    .N_TAPS(N), .CODE_W(CW), .FILT_LEN(4), .LOCK_CNT(8), .INIT_TAP(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .vote_vld(vote_vld),
    .phase_up(phase_up), .phase_dn(phase_dn), .man_load(man_load),
    .man_code(man_code), .lambda(lambda), .lambda_bar(lambda_bar),
    .tap_code(tap_code), .busy(busy), .sat(sat), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input logic up, input logic dn, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      vote_vld = 1'b1;
      phase_up = up;
      phase_dn = dn;
      tick();
    end
    vote_vld = 1'b0;
    phase_up = 1'b0;
    phase_dn = 1'b0;
  endtask

  task automatic load(input logic [CW-1:0] code);
    man_code = code;
    man_load = 1'b1;
    tick();
    man_load = 1'b0;
  endtask

  task automatic settled(input string tag, input logic [7:0] lam, input logic [7:0] bar,
                         input logic [3:0] tap);
    check({tag, ".lambda"}, 32'(lambda), 32'(lam));
    check({tag, ".lambda_bar"}, 32'(lambda_bar), 32'(bar));
    check({tag, ".tap_code"}, 32'(tap_code), 32'(tap));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Called right after the edge that accepted the request.
  task automatic seq(input string tag, input logic [7:0] brk, input logic [7:0] lam,
                     input logic [7:0] bar, input logic [3:0] tap);
    check({tag, ".busy0"}, 32'(busy), 32'd1);
    tick();
    check({tag, ".brk_lambda"}, 32'(lambda), 32'd0);
    check({tag, ".brk_bar"}, 32'(lambda_bar), 32'(brk));
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    tick();
    settled(tag, lam, bar, tap);
  endtask

  initial begin
    repeat (2) tick();
    settled("reset", 8'h01, 8'h00, 4'd0);
    check("reset.sat", 32'(sat), 32'd0);
    check("reset.locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // Single up step from tap 0
    vote(1'b1, 1'b0, 3);
    check("up3.busy", 32'(busy), 32'd0);
    vote(1'b1, 1'b0, 1);
    check("up4.lambda_held", 32'(lambda), 32'h01);
    seq("step0to1", 8'h00, 8'h02, 8'h01, 4'd1);

    // Manual loads: jump, no-op, clamp
    load(4'd5);
    seq("load5", 8'h01, 8'h20, 8'h1F, 4'd5);
    load(4'd5);
    settled("load5_noop", 8'h20, 8'h1F, 4'd5);
    load(4'd9);
    seq("load9_clamp", 8'h1F, 8'h80, 8'h7F, 4'd7);

    // Up limit
    vote(1'b1, 1'b0, 4);
    check("sat_hi.pulse", 32'(sat), 32'd1);
    check("sat_hi.busy", 32'(busy), 32'd0);
    tick();
    check("sat_hi.drop", 32'(sat), 32'd0);
    settled("sat_hi", 8'h80, 8'h7F, 4'd7);

    // Down step with votes presented during BREAK/MAKE, which must be dropped
    vote(1'b0, 1'b1, 4);
    check("dn7.busy", 32'(busy), 32'd1);
    vote_vld = 1'b1;
    phase_dn = 1'b1;
    tick();
    check("dn7.brk_bar", 32'(lambda_bar), 32'h3F);
    tick();
    vote_vld = 1'b0;
    phase_dn = 1'b0;
    settled("dn7", 8'h40, 8'h3F, 4'd6);

    // Mixed votes leave the accumulator alone
    vote(1'b1, 1'b1, 4);
    check("mixed.busy", 32'(busy), 32'd0);
    vote(1'b0, 1'b1, 3);
    check("dn3_after_drop.busy", 32'(busy), 32'd0);
    vote(1'b0, 1'b1, 1);
    seq("step6to5", 8'h1F, 8'h20, 8'h1F, 4'd5);

    // Down limit
    load(4'd0);
    seq("load0", 8'h00, 8'h01, 8'h00, 4'd0);
    vote(1'b0, 1'b1, 4);
    check("sat_lo.pulse", 32'(sat), 32'd1);
    tick();
    check("sat_lo.drop", 32'(sat), 32'd0);
    settled("sat_lo", 8'h01, 8'h00, 4'd0);

    // Alternating steps: reversal k-1 completes with step k
    for (int k = 1; k <= 9; k++) begin
      if (k % 2 == 1) begin
        vote(1'b1, 1'b0, 4);
        seq($sformatf("alt%0d", k), 8'h00, 8'h02, 8'h01, 4'd1);
      end else begin
        vote(1'b0, 1'b1, 4);
        seq($sformatf("alt%0d", k), 8'h00, 8'h01, 8'h00, 4'd0);
      end
      check($sformatf("alt%0d.locked", k), 32'(locked), 32'(LOCK_EN && (k >= 9)));
    end
    vote(1'b1, 1'b0, 4);
    seq("same_dir", 8'h01, 8'h04, 8'h03, 4'd2);
    check("same_dir.locked", 32'(locked), 32'd0);

    // Asynchronous reset in the middle of BREAK
    vote(1'b1, 1'b0, 4);
    tick();
    check("rst_mid.brk_lambda", 32'(lambda), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    settled("rst_mid", 8'h01, 8'h00, 4'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    settled("rst_after", 8'h01, 8'h00, 4'd0);

    // en low: votes ignored and accumulator held at zero
    en = 1'b0;
    vote(1'b1, 1'b0, 4);
    check("en_off.busy", 32'(busy), 32'd0);
    en = 1'b1;
    vote(1'b1, 1'b0, 3);
    check("en_on3.busy", 32'(busy), 32'd0);
    vote(1'b1, 1'b0, 1);
    seq("en_on_step", 8'h00, 8'h02, 8'h01, 4'd1);
    check("final.locked", 32'(locked), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tdl_phase_ctrl.md
# tdl_phase_ctrl

Registered controller that drives the tap-select buses (`lambda`/`lambda_bar`) of an N-tap tristate tapped delay line.
- Filters bang-bang phase-detector votes into single-tap steps.
- Sequences every code change break-before-make so two tristate drivers never share a node.
- Supports manual code load and, optionally, lock detection.
- Sits between the phase detector and the TDL macro in the clock-alignment loop.

## Interface
- `N_TAPS`, 8: number of selectable taps (≥2).
- `CODE_W`, 3: tap-code width, ≥ clog2(N_TAPS).
- `FILT_LEN`, 4: net votes needed to request one step (≥1).
- `LOCK_CNT`, 8: consecutive direction reversals needed to assert lock (≥1).
- `INIT_TAP`, 0: tap selected after reset (< N_TAPS).

Ports:
- `clk` input 1: controller clock.
- `rst_n` input 1: reset. Asynchronous assertion, active-low. This is fixed.
- `en` input 1: loop enable. When low, votes are ignored and the accumulator is held at 0.
- `vote_vld` input 1: the phase-detector outputs are valid this cycle.
- `phase_up` input 1: request more delay.
- `phase_dn` input 1: request less delay.
- `man_load` input 1: single-cycle pulse that loads `man_code`.
- `man_code` input CODE_W: manual tap code.
- `lambda` output N_TAPS: one-hot final-stage enable.
- `lambda_bar` output N_TAPS: pass-through enables.
- `tap_code` output CODE_W: currently applied tap.
- `busy` output 1: a step sequence is in progress.
- `sat` output 1: one-cycle pulse when a step request is discarded at a limit.
- `locked` output 1: lock indication.

## Operation
- Encoding for applied tap t (0-based):
  - `lambda[k]` = (k==t).
  - `lambda_bar[k]` = (k<t).
  - `lambda_bar[N_TAPS-1]` is always 0.
- Vote filter: signed accumulator `acc`, range ±FILT_LEN.
  - Valid vote in IDLE with `en`=1: `up` only → +1; `dn` only → −1; both or neither → no change.
  - `acc` = +FILT_LEN → request t+1. `acc` = −FILT_LEN → request t−1. `acc` clears to 0 on the same edge.
- Limits:
  - Up request at t=N_TAPS−1, or down request at t=0, is discarded.
  - `acc` is cleared, `sat` pulses for 1 cycle, and no sequence starts.
- FSM states: IDLE, BREAK, MAKE.
  - IDLE → BREAK on a step request or `man_load`.
  - BREAK (1 cycle): `lambda`=0; `lambda_bar` = old pattern AND new pattern.
  - MAKE (1 cycle): new `lambda`/`lambda_bar` and `tap_code` applied, then → IDLE.
  - `busy`=1 in BREAK and MAKE.
  - Votes and `man_load` arriving during BREAK or MAKE are dropped.
- Manual load:
  - `man_code` ≥ N_TAPS is clamped to N_TAPS−1.
  - A load may jump any distance, through one BREAK/MAKE pair.
  - `man_code` equal to t is a no-op: no BREAK, FSM stays in IDLE.
  - `acc` is cleared on every load.
  - `man_load` takes priority over a simultaneous vote-threshold request.
- `en` deasserted mid-sequence: the sequence completes. Votes are ignored from the next cycle.

## Timing
- Reset values (rst_n low):
  - `tap_code`=INIT_TAP; `lambda`/`lambda_bar` = encoding of INIT_TAP.
  - `acc`=0, state IDLE.
  - `busy`=0, `sat`=0, `locked`=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Step latency:
  - Threshold vote sampled at edge n.
  - BREAK pattern visible after edge n+1.
  - New code visible after edge n+2.
  - Next vote is accepted at edge n+3.
- Manual load: same latency, measured from the `man_load` sample edge.
- `sat` is high for exactly the cycle after the discarding edge.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous).

## Configuration
- `TDL_LOCK_DET_EN` defined:
  - A reversal counter increments when a completed step is opposite in direction to the previous step.
  - Two consecutive same-direction steps clear the counter.
  - `locked` rises when the counter reaches LOCK_CNT; the counter saturates there.
  - `locked` is cleared, together with the counter, on two consecutive same-direction steps, on `man_load`, on `en`=0, or on `sat`.
- `TDL_LOCK_DET_EN` undefined: no counter is built and `locked` is tied to 0.

## Test plan
- Reset with defaults → `lambda`=8'h01, `lambda_bar`=8'h00, `tap_code`=0, `busy`=0.
- 4 valid `phase_up` votes from tap 0 → BREAK with `lambda`=8'h00, `lambda_bar`=8'h00; then `lambda`=8'h02, `lambda_bar`=8'h01, `tap_code`=1, two edges after the 4th vote.
- At tap 7, 4 up votes → `sat` pulses once, codes unchanged. Mixed votes (`up`+`dn` together) → `acc` unchanged.
- `man_load` with `man_code`=5 from tap 1 → BREAK `lambda_bar`=8'h01, then `lambda`=8'h20, `lambda_bar`=8'h1F. `man_code`=9 with N_TAPS=8 → clamped to tap 7.
- Alternating up/down bursts (4 votes each) with `TDL_LOCK_DET_EN` defined → `locked`=1 after the 8th reversal; two consecutive up steps → `locked`=0. With the macro undefined, `locked` stays 0 throughout.
- `rst_n` pulsed low during BREAK → immediate return to INIT_TAP encoding. Votes during `busy` are dropped (`acc` unchanged).
